// File: rtl/iob_fifo2stream_pkg.sv
// iob_fifo2stream_pkg: occupancy type and constants shared by the FIFO drain stage.
package iob_fifo2stream_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/iob_skid_buf2.sv
// iob_skid_buf2: 2-entry valid/ready buffer with head/tail pointers and occupancy output.
module iob_skid_buf2
    import iob_fifo2stream_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              valid_o,
    output occ_t              occ_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              head_q;
    logic              tail_q;
    occ_t              occ_q;
    occ_t              occ_d;
    logic              pop;

    assign pop       = rd_i & (occ_q != OCC_EMPTY);
    assign occ_d     = occ_q + (wr_i ? OCC_ONE : OCC_EMPTY) - (pop ? OCC_ONE : OCC_EMPTY);
    assign rd_data_o = mem_q[head_q];
    assign valid_o   = occ_q != OCC_EMPTY;
    assign occ_o     = occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= OCC_EMPTY;
        end else begin
            if (wr_i) begin
                mem_q[tail_q] <= wr_data_i;
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/iob_fifo2stream.sv
// iob_fifo2stream: drains an async FIFO read port into a valid/ready stream.
// Define IOB_FIFO2STREAM_CNT_EN to add the accepted-word counter (xfer_cnt/cnt_clr).
module iob_fifo2stream
    import iob_fifo2stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef IOB_FIFO2STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]  xfer_cnt,
    input  logic              cnt_clr
`endif
);

    logic inflight_q;
    logic pop;
    occ_t occ;

    assign pop = out_valid & out_ready;
    // Reserve a slot for the in-flight word so the buffer can never overflow.
    assign fifo_read = rst & en & ~fifo_empty &
                       (({1'b0, occ} + {2'b00, inflight_q}) < ({1'b0, OCC_FULL} + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_q <= 1'b0;
        else      inflight_q <= fifo_read;
    end

    iob_skid_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (inflight_q),
        .wr_data_i (fifo_data),
        .rd_i      (out_ready),
        .rd_data_o (out_data),
        .valid_o   (out_valid),
        .occ_o     (occ)
    );

`ifdef IOB_FIFO2STREAM_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d    = cnt_clr ? '0 : cnt_q + CNT_W'(pop);
    assign xfer_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif

endmodule
